// File: rtl/seq_multiplier_pkg.sv
// Shared ALU package: FSM state encoding for the sequential arithmetic units.
// The multiplier uses it now, and a later sequential divider can reuse it.
package seq_multiplier_pkg;

  // Control states of a multi-cycle ALU operation.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Sequential signed multiplier using radix-2 Booth recoding.
// It retires one multiplier bit per cycle and delivers the full 2n-bit product
// as out (low half) and prod_hi (high half), plus an n-bit overflow flag.
//
// Handshake: start is sampled only while IDLE. An operation takes exactly
// n CALC cycles. done then pulses for one cycle in DONE, with the results
// already registered. start seen in CALC or DONE is dropped, not queued.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic [n-1:0] out,
  output logic [n-1:0] prod_hi,
  output logic         overflow,
  output logic         car,
  output logic         busy,
  output logic         done,
  output fsm_state_e   state_o
);

  localparam int CW = $clog2(n + 1);

  fsm_state_e      state_q;
  logic [CW-1:0]   cnt_q;
  // Multiplicand and accumulator carry one guard bit, so that -2^(n-1)
  // can be negated without wrapping.
  logic [n:0]      m_q;
  logic [n:0]      acc_q;
  logic [n-1:0]    q_q;
  logic            qm1_q;
  logic [n-1:0]    out_q;
  logic [n-1:0]    hi_q;
  logic            ovf_q;
  logic            busy_q;
  logic            done_q;

  logic [n:0]      sum_d;
  logic [n:0]      acc_d;
  logic [n-1:0]    q_d;
  logic            qm1_d;
  logic            ovf_d;

  // One Booth step: add or subtract the multiplicand by {Q[0], q-1}, then
  // shift {acc, Q, q-1} arithmetically right by one.
  always_comb begin
    sum_d = acc_q;
    case ({q_q[0], qm1_q})
      2'b01:   sum_d = acc_q + m_q;
      2'b10:   sum_d = acc_q - m_q;
      default: sum_d = acc_q;
    endcase
    acc_d = {sum_d[n], sum_d[n:1]};
    q_d   = {sum_d[0], q_q[n-1:1]};
    qm1_d = q_q[0];
    // The product fits in n signed bits only when the high half is pure
    // sign extension of the low half.
    ovf_d = (acc_d[n-1:0] != {n{q_d[n-1]}});
  end

  // Control FSM plus datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      out_q   <= '0;
      hi_q    <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            m_q     <= {A[n-1], A};
            acc_q   <= '0;
            q_q     <= B;
            qm1_q   <= 1'b0;
            cnt_q   <= CW'(n);
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          qm1_q <= qm1_d;
          cnt_q <= cnt_q - CW'(1);
          // The last step's result goes straight into the output registers.
          if (cnt_q == CW'(1)) begin
            out_q   <= q_d;
            hi_q    <= acc_d[n-1:0];
            ovf_q   <= ovf_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out      = out_q;
  assign prod_hi  = hi_q;
  assign overflow = ovf_q;
  assign car      = 1'b0;
  assign busy     = busy_q;
  assign done     = done_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier (n = 8): directed spec vectors, a restart in
// flight, reset in flight, and randomized operands with A/B churn during CALC.
module tb_seq_multiplier;
  import seq_multiplier_pkg::*;

  localparam int N = 8;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic [N-1:0] out;
  logic [N-1:0] prod_hi;
  logic         overflow;
  logic         car;
  logic         busy;
  logic         done;
  fsm_state_e   state_o;

  always #5 clk = ~clk;

  seq_multiplier #(.n(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .A        (A),
    .B        (B),
    .out      (out),
    .prod_hi  (prod_hi),
    .overflow (overflow),
    .car      (car),
    .busy     (busy),
    .done     (done),
    .state_o  (state_o)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  logic [2*N:0] exp_q[$];   // {overflow, prod_hi, out}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed product of the captured operands.
  function automatic logic [2*N:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
    int p;
    logic [2*N-1:0] p16;
    logic ovf;
    p   = int'($signed(a)) * int'($signed(b));
    p16 = p[2*N-1:0];
    ovf = (p > 127) || (p < -128);
    return {ovf, p16};
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge while the DUT is IDLE. churn changes A/B every CALC
  // cycle. restart_at > 0 re-pulses start with new operands in that CALC cycle.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input bit churn, input int restart_at);
    int k;
    bit busy_ok;
    int done_cnt;
    logic [2*N:0] exp;
    exp_q.push_back(model(a, b));
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);            // t0: start sampled
    @(negedge clk);
    start = 1'b0;
    k = 0;
    busy_ok = 1'b1;
    while (!done && k < 20) begin
      if (busy !== 1'b1 || state_o !== CALC) busy_ok = 1'b0;
      if (churn) begin
        A = N'($urandom);
        B = N'($urandom);
      end
      if (restart_at > 0 && k == restart_at) begin
        start = 1'b1;
        A = 8'h55;
        B = 8'h7F;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    start = 1'b0;
    check("latency", 32'(k), 32'(N));
    check("busy_in_calc", 32'(busy_ok), 32'd1);
    exp = exp_q.pop_front();
    check("out", 32'(out), 32'(exp[N-1:0]));
    check("prod_hi", 32'(prod_hi), 32'(exp[2*N-1:N]));
    check("overflow", 32'(overflow), 32'(exp[2*N]));
    check("car", 32'(car), 32'd0);
    check("busy_in_done", 32'(busy), 32'd0);
    // done must be a single pulse; outputs then hold with the FSM in IDLE.
    done_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("done_single_pulse", 32'(done_cnt), 32'd0);
    check("state_idle_after", 32'(state_o), 32'(IDLE));
    check("hold_out", 32'({overflow, prod_hi, out}), 32'(exp));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int done_cnt;
    // Reset values
    #2;
    check("rst_out", 32'(out), 32'd0);
    check("rst_prod_hi", 32'(prod_hi), 32'd0);
    check("rst_flags", 32'({overflow, car, busy, done}), 32'd0);
    check("rst_state", 32'(state_o), 32'(IDLE));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // start is honoured on the very first edge after release
    run_op(8'd3, 8'd5, 1'b0, 0);
    check("v30_out", 32'(out), 32'h0F);
    check("v30_hi", 32'(prod_hi), 32'h00);
    check("v30_ovf", 32'(overflow), 32'd0);

    run_op(8'hF9, 8'd6, 1'b0, 0);              // -7 * 6
    check("v31_out", 32'(out), 32'hD6);
    check("v31_hi", 32'(prod_hi), 32'hFF);

    run_op(8'd16, 8'd16, 1'b0, 0);
    check("v32a_out", 32'(out), 32'h00);
    check("v32a_hi", 32'(prod_hi), 32'h01);
    check("v32a_ovf", 32'(overflow), 32'd1);

    run_op(8'h80, 8'h80, 1'b0, 0);             // -128 * -128
    check("v32b_out", 32'(out), 32'h00);
    check("v32b_hi", 32'(prod_hi), 32'h40);
    check("v32b_ovf", 32'(overflow), 32'd1);

    // Other edges of the signed range
    run_op(8'h80, 8'h7F, 1'b0, 0);
    run_op(8'h7F, 8'h7F, 1'b0, 0);
    run_op(8'hFF, 8'hFF, 1'b0, 0);
    run_op(8'h00, 8'h9C, 1'b0, 0);
    run_op(8'h80, 8'h01, 1'b0, 0);

    // start re-pulsed in CALC cycle 3 is ignored; operand churn too
    run_op(8'd10, 8'hFB, 1'b1, 3);             // 10 * -5
    check("v33_out", 32'(out), 32'hCE);
    check("v33_hi", 32'(prod_hi), 32'hFF);

    // Reset during CALC cycle 4
    A = 8'd9;
    B = 8'd9;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_out", 32'(out), 32'd0);
    check("midrst_prod_hi", 32'(prod_hi), 32'd0);
    check("midrst_flags", 32'({overflow, car, busy, done}), 32'd0);
    check("midrst_state", 32'(state_o), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    check("midrst_idle", 32'(state_o), 32'(IDLE));

    run_op(8'd2, 8'hFD, 1'b0, 0);              // 2 * -3
    check("v34_out", 32'(out), 32'hFA);
    check("v34_hi", 32'(prod_hi), 32'hFF);

    // Randomized operands, with A/B changing during every CALC cycle
    for (int i = 0; i < 24; i++) begin
      run_op(N'($urandom_range(0, 255)), N'($urandom_range(0, 255)), 1'b1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
